// File: rtl/mem_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl_param
// Purpose  : Single-port word memory with valid/ready requests, byte-enabled
//            writes, fixed-latency in-order responses and a sequential clear.
// Revision : 1.0 - initial release
// ============================================================================
module mem_ctrl_param #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 4,
    parameter int                    DEPTH      = 16,
    parameter int                    RD_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    en,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic [DATA_WIDTH/8-1:0] be,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    valid_out,
    output logic                    resp_wr,
    output logic                    err_out,
    output logic                    busy
);

    localparam int                    c_nbytes = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0]   c_depth  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] c_last   = ADDR_WIDTH'(DEPTH - 1);

    localparam logic [0:0] c_st_init = 1'b0;
    localparam logic [0:0] c_st_run  = 1'b1;

    logic [0:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [RD_LATENCY-1:0] r_pv;
    logic [RD_LATENCY-1:0] r_pw;
    logic [RD_LATENCY-1:0] r_pe;
    logic [DATA_WIDTH-1:0] r_pd [RD_LATENCY];

    logic w_init;
    logic w_acc;
    logic w_inr;
    logic w_wr;
    logic w_rd;

    assign w_init    = (r_state == c_st_init);
    assign busy      = w_init;
    assign req_ready = ~w_init & ~clr;
    assign w_acc     = req_valid & req_ready;
    assign w_inr     = ({1'b0, addr} < c_depth);
    assign w_wr      = w_acc & en & w_inr;
    assign w_rd      = w_acc & ~en & w_inr;

    // clr restarts the sweep from word 0 whether we are sweeping or running
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_st_init;
            r_idx   <= '0;
        end else if (clr) begin
            r_state <= c_st_init;
            r_idx   <= '0;
        end else if (w_init) begin
            if (r_idx == c_last) begin
                r_state <= c_st_run;
                r_idx   <= '0;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_init) begin
            r_mem[r_idx] <= INIT_VALUE;
        end else if (w_wr) begin
            for (int b = 0; b < c_nbytes; b++) begin
                if (be[b]) begin
                    r_mem[addr][8*b +: 8] <= data_in[8*b +: 8];
                end
            end
        end
    end

    // Stage 0 captures the response at the accept edge; later stages just shift
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pv <= '0;
            r_pw <= '0;
            r_pe <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                r_pd[i] <= '0;
            end
        end else begin
            r_pv[0] <= w_acc;
            r_pw[0] <= w_acc & en;
            r_pe[0] <= w_acc & ~w_inr;
            r_pd[0] <= w_rd ? r_mem[addr] : '0;
            for (int i = RD_LATENCY - 1; i > 0; i--) begin
                r_pv[i] <= r_pv[i-1];
                r_pw[i] <= r_pw[i-1];
                r_pe[i] <= r_pe[i-1];
                r_pd[i] <= r_pd[i-1];
            end
        end
    end

    assign valid_out = r_pv[RD_LATENCY-1];
    assign resp_wr   = r_pw[RD_LATENCY-1];
    assign err_out   = r_pe[RD_LATENCY-1];
    assign data_out  = r_pd[RD_LATENCY-1];

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_ctrl_param
// Purpose  : Directed bench: unit 0 is DEPTH=16/latency 1, unit 1 is
//            DEPTH=12/latency 3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl_param;

    logic        clk = 1'b0;
    logic [1:0]  rst;
    logic [1:0]  clr;
    logic [1:0]  req_valid;
    logic [1:0]  en;
    logic [3:0]  addr [2];
    logic [31:0] din  [2];
    logic [3:0]  be   [2];
    logic [1:0]  req_ready;
    logic [1:0]  valid_out;
    logic [1:0]  resp_wr;
    logic [1:0]  err_out;
    logic [1:0]  busy;
    logic [31:0] dout [2];

    logic [31:0] mdl [2][16];
    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_ctrl_param #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .DEPTH(16), .RD_LATENCY(1),
                     .INIT_VALUE(32'h0)) u_dut0 (
        .clk(clk), .rst(rst[0]), .clr(clr[0]), .req_valid(req_valid[0]),
        .req_ready(req_ready[0]), .en(en[0]), .addr(addr[0]), .data_in(din[0]),
        .be(be[0]), .data_out(dout[0]), .valid_out(valid_out[0]),
        .resp_wr(resp_wr[0]), .err_out(err_out[0]), .busy(busy[0])
    );

    mem_ctrl_param #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .DEPTH(12), .RD_LATENCY(3),
                     .INIT_VALUE(32'h0)) u_dut1 (
        .clk(clk), .rst(rst[1]), .clr(clr[1]), .req_valid(req_valid[1]),
        .req_ready(req_ready[1]), .en(en[1]), .addr(addr[1]), .data_in(din[1]),
        .be(be[1]), .data_out(dout[1]), .valid_out(valid_out[1]),
        .resp_wr(resp_wr[1]), .err_out(err_out[1]), .busy(busy[1])
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d, input logic v, input logic w, input int a,
                         input logic [31:0] data, input logic [3:0] bm);
        req_valid[d] = v;
        en[d]        = w;
        addr[d]      = 4'(a);
        din[d]       = data;
        be[d]        = bm;
    endtask

    // Reads words 0..n-1 back to back and checks them against the model
    task automatic rd_stream(input int d, input int lat, input int n);
        int j;
        for (int k = 0; k < n + lat; k++) begin
            if (k < n) drive(d, 1'b1, 1'b0, k, 32'h0, 4'hF);
            else       req_valid[d] = 1'b0;
            step();
            j = k - (lat - 1);
            if (j >= 0 && j < n) begin
                chk($sformatf("u%0d_rd_valid_%0d", d, j), 32'(valid_out[d]), 32'd1);
                chk($sformatf("u%0d_rd_data_%0d", d, j), dout[d], mdl[d][j]);
                chk($sformatf("u%0d_rd_err_%0d", d, j), 32'(err_out[d]), 32'd0);
            end else begin
                chk($sformatf("u%0d_rd_idle_%0d", d, k), 32'(valid_out[d]), 32'd0);
            end
        end
        req_valid[d] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int c0, c1, cnt, stale;
        rst = 2'b00; clr = 2'b00; req_valid = 2'b00; en = 2'b00;
        for (int d = 0; d < 2; d++) begin
            addr[d] = '0; din[d] = '0; be[d] = '0;
            for (int a = 0; a < 16; a++) mdl[d][a] = 32'h0;
        end

        // ---------------- reset and initial clear ----------------
        step(); step();
        chk("rst_busy",   32'(busy),      32'h3);
        chk("rst_ready",  32'(req_ready), 32'h0);
        chk("rst_valid",  32'(valid_out), 32'h0);
        chk("rst_dout0",  dout[0],        32'h0);
        rst = 2'b11;
        c0 = 0; c1 = 0; cnt = 0;
        while ((c0 == 0 || c1 == 0) && cnt < 40) begin
            step();
            cnt++;
            if (!busy[0] && c0 == 0) c0 = cnt;
            if (!busy[1] && c1 == 0) c1 = cnt;
        end
        chk("init_edges_u0", 32'(c0), 32'd16);
        chk("init_edges_u1", 32'(c1), 32'd12);
        chk("ready_after_init", 32'(req_ready), 32'h3);

        // ---------------- unit 0: all words cleared ----------------
        rd_stream(0, 1, 16);

        // ---------------- unit 0: byte enables ----------------
        drive(0, 1'b1, 1'b1, 3, 32'hAABBCCDD, 4'hF);
        step();
        chk("be_wr1_valid", 32'(valid_out[0]), 32'd1);
        chk("be_wr1_rwr",   32'(resp_wr[0]),   32'd1);
        chk("be_wr1_data",  dout[0],           32'h0);
        drive(0, 1'b1, 1'b1, 3, 32'h11223344, 4'b0101);
        step();
        chk("be_wr2_rwr",   32'(resp_wr[0]),   32'd1);
        drive(0, 1'b1, 1'b0, 3, 32'h0, 4'hF);
        step();
        chk("be_rd_data",   dout[0],           32'hAA22CC44);
        chk("be_rd_rwr",    32'(resp_wr[0]),   32'd0);

        // ---------------- unit 0: write then read next edge ----------------
        drive(0, 1'b1, 1'b1, 5, 32'h12345678, 4'hF);
        step();
        drive(0, 1'b1, 1'b0, 5, 32'h0, 4'hF);
        step();
        chk("b2b_data", dout[0], 32'h12345678);
        req_valid[0] = 1'b0;
        step();
        chk("idle_u0", 32'(valid_out[0]), 32'd0);

        // ---------------- unit 1: fill words 0..7, then stream ----------------
        for (int k = 0; k < 8; k++) begin
            drive(1, 1'b1, 1'b1, k, 32'h10000000 + 32'(k) * 32'h111, 4'hF);
            mdl[1][k] = 32'h10000000 + 32'(k) * 32'h111;
            step();
        end
        req_valid[1] = 1'b0;
        repeat (4) step();
        rd_stream(1, 3, 8);

        // ---------------- unit 1: out-of-range ----------------
        drive(1, 1'b1, 1'b1, 13, 32'hDEADBEEF, 4'hF);
        step();
        drive(1, 1'b1, 1'b0, 13, 32'h0, 4'hF);
        step();
        req_valid[1] = 1'b0;
        step();
        chk("oor_wr_valid", 32'(valid_out[1]), 32'd1);
        chk("oor_wr_err",   32'(err_out[1]),   32'd1);
        chk("oor_wr_rwr",   32'(resp_wr[1]),   32'd1);
        chk("oor_wr_data",  dout[1],           32'h0);
        step();
        chk("oor_rd_valid", 32'(valid_out[1]), 32'd1);
        chk("oor_rd_err",   32'(err_out[1]),   32'd1);
        chk("oor_rd_rwr",   32'(resp_wr[1]),   32'd0);
        chk("oor_rd_data",  dout[1],           32'h0);
        step();
        rd_stream(1, 3, 12);

        // ---------------- unit 1: clr with reads in flight ----------------
        drive(1, 1'b1, 1'b0, 1, 32'h0, 4'hF);
        step();
        drive(1, 1'b1, 1'b0, 2, 32'h0, 4'hF);
        step();
        drive(1, 1'b1, 1'b0, 3, 32'h0, 4'hF);
        clr[1] = 1'b1;
        #1;
        chk("clr_ready_low", 32'(req_ready[1]), 32'd0);
        step();
        chk("clr_busy",      32'(busy[1]),      32'd1);
        chk("clr_fl1_valid", 32'(valid_out[1]), 32'd1);
        chk("clr_fl1_data",  dout[1],           mdl[1][1]);
        clr[1] = 1'b0;
        req_valid[1] = 1'b0;
        cnt = 0;
        while (busy[1] && cnt < 40) begin
            step();
            cnt++;
            if (cnt == 1) chk("clr_fl2_data", dout[1], mdl[1][2]);
            if (cnt == 2) chk("clr_third_dropped", 32'(valid_out[1]), 32'd0);
        end
        chk("clr_busy_edges", 32'(cnt), 32'd12);
        for (int a = 0; a < 16; a++) mdl[1][a] = 32'h0;
        rd_stream(1, 3, 12);

        // ---------------- unit 1: async reset with responses in flight ----------------
        drive(1, 1'b1, 1'b1, 4, 32'hCAFEF00D, 4'hF);
        step();
        req_valid[1] = 1'b0;
        repeat (3) step();
        drive(1, 1'b1, 1'b0, 4, 32'h0, 4'hF);
        repeat (3) step();
        chk("arst_pre_valid", 32'(valid_out[1]), 32'd1);
        chk("arst_pre_data",  dout[1],           32'hCAFEF00D);
        req_valid[1] = 1'b0;
        #2;
        rst[1] = 1'b0;
        #1;
        chk("arst_valid", 32'(valid_out[1]), 32'd0);
        chk("arst_data",  dout[1],           32'h0);
        chk("arst_ready", 32'(req_ready[1]), 32'd0);
        chk("arst_busy",  32'(busy[1]),      32'd1);
        step();
        #2;
        rst[1] = 1'b1;
        cnt = 0;
        stale = 0;
        while (busy[1] && cnt < 40) begin
            step();
            cnt++;
            if (valid_out[1]) stale = 1;
        end
        chk("arst_no_stale",   32'(stale), 32'd0);
        chk("arst_init_edges", 32'(cnt),   32'd12);
        for (int a = 0; a < 16; a++) mdl[1][a] = 32'h0;
        rd_stream(1, 3, 12);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
